// File: rtl/knockout_trigger_sequencer.sv
// Knockout trigger sequencer.
// Steps through a small table of trigger stages. For each stage it loads the
// slot patterns into the two-slot comparator and counts qualified comparator
// matches. When a stage's occurrence count is reached it fires a one-cycle
// knockout pulse and moves on to the next stage.
module knockout_trigger_sequencer #(
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 8,
    parameter int TRIG_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [31:0]              cfg_inst0,
    input  logic [31:0]              cfg_inst1,
    input  logic [1:0]               cfg_mode,
    input  logic [CNT_W-1:0]         cfg_count,
    input  logic                     cfg_last,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic                     inst_valid,
    input  logic                     trig1,
    input  logic                     trig2,
    output logic [31:0]              inst0_trig,
    output logic [31:0]              inst1_trig,
    output logic                     knockout,
    output logic [$clog2(DEPTH)-1:0] stage,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     busy,
    output logic                     done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SW  = $clog2(TRIG_LAT + 1);
    localparam int CW1 = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Trigger table. It is cleared by reset, so it lives in flops.
    logic [31:0]      tbl_inst0 [DEPTH];
    logic [31:0]      tbl_inst1 [DEPTH];
    logic [1:0]       tbl_mode  [DEPTH];
    logic [CNT_W-1:0] tbl_count [DEPTH];
    logic             tbl_last  [DEPTH];

    state_t           state_reg, state_next;
    logic [AW-1:0]    stage_reg, stage_next;
    logic [CNT_W-1:0] hit_count_reg, hit_count_next;
    logic [31:0]      inst0_reg, inst0_next;
    logic [31:0]      inst1_reg, inst1_next;
    logic [SW-1:0]    settle_reg, settle_next;
    logic             knockout_reg, knockout_next;

    logic [TRIG_LAT-1:0] vd_reg, vd_next;
    logic                qv;
    logic                table_we;
    logic                hit;
    logic [1:0]          cur_mode;
    logic [CNT_W-1:0]    cur_count;
    logic                cur_last;
    logic [CW1-1:0]      hit_plus;
    logic [CW1-1:0]      need;
    logic [AW-1:0]       stage_inc;

    // Valid delay pipe: aligns inst_valid with the comparator's trig outputs.
    genvar gi;
    generate
        for (gi = 0; gi < TRIG_LAT; gi++) begin : g_vd
            if (gi == 0) begin : g_head
                assign vd_next[gi] = inst_valid;
            end else begin : g_tail
                assign vd_next[gi] = vd_reg[gi-1];
            end
        end
    endgenerate

    // Shift the valid pipe every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vd_reg <= '0;
        end else begin
            vd_reg <= vd_next;
        end
    end

    assign qv = vd_reg[TRIG_LAT-1];

    // Configuration is only accepted while idle so a running sequence is stable.
    assign table_we = cfg_we && (state_reg == IDLE);

    // Table write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_inst0[i] <= '0;
                tbl_inst1[i] <= '0;
                tbl_mode[i]  <= '0;
                tbl_count[i] <= '0;
                tbl_last[i]  <= 1'b0;
            end
        end else if (table_we) begin
            tbl_inst0[cfg_addr] <= cfg_inst0;
            tbl_inst1[cfg_addr] <= cfg_inst1;
            tbl_mode[cfg_addr]  <= cfg_mode;
            tbl_count[cfg_addr] <= cfg_count;
            tbl_last[cfg_addr]  <= cfg_last;
        end
    end

    assign cur_mode  = tbl_mode[stage_reg];
    assign cur_count = tbl_count[stage_reg];
    assign cur_last  = tbl_last[stage_reg];
    assign stage_inc = stage_reg + AW'(1);

    // A simultaneous trig1/trig2 is one hit; a zero count behaves like one.
    assign hit      = (state_reg == ARMED) && qv &&
                      ((cur_mode[0] && trig1) || (cur_mode[1] && trig2));
    assign hit_plus = {1'b0, hit_count_reg} + CW1'(1);
    assign need     = (cur_count == '0) ? CW1'(1) : {1'b0, cur_count};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            stage_reg     <= '0;
            hit_count_reg <= '0;
            inst0_reg     <= '0;
            inst1_reg     <= '0;
            settle_reg    <= '0;
            knockout_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            hit_count_reg <= hit_count_next;
            inst0_reg     <= inst0_next;
            inst1_reg     <= inst1_next;
            settle_reg    <= settle_next;
            knockout_reg  <= knockout_next;
        end
    end

    // Next-state logic; disarm overrides everything including a final hit.
    always_comb begin
        state_next     = state_reg;
        stage_next     = stage_reg;
        hit_count_next = hit_count_reg;
        inst0_next     = inst0_reg;
        inst1_next     = inst1_reg;
        settle_next    = settle_reg;
        knockout_next  = 1'b0;

        if (disarm) begin
            state_next     = IDLE;
            stage_next     = '0;
            hit_count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arm) begin
                        stage_next     = '0;
                        hit_count_next = '0;
                        inst0_next     = tbl_inst0[0];
                        inst1_next     = tbl_inst1[0];
                        settle_next    = SW'(TRIG_LAT);
                        state_next     = SETTLE;
                    end
                end
                SETTLE: begin
                    // Wait out the comparator latency for the new pattern.
                    if (settle_reg == SW'(1)) begin
                        state_next = ARMED;
                    end else begin
                        settle_next = settle_reg - SW'(1);
                    end
                end
                ARMED: begin
                    if (hit) begin
                        if (hit_plus < need) begin
                            hit_count_next = hit_count_reg + CNT_W'(1);
                        end else begin
                            knockout_next  = 1'b1;
                            hit_count_next = '0;
                            if (cur_last || (stage_reg == AW'(DEPTH - 1))) begin
                                state_next = DONE;
                            end else begin
                                stage_next  = stage_inc;
                                inst0_next  = tbl_inst0[stage_inc];
                                inst1_next  = tbl_inst1[stage_inc];
                                settle_next = SW'(TRIG_LAT);
                                state_next  = SETTLE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign inst0_trig = inst0_reg;
    assign inst1_trig = inst1_reg;
    assign knockout   = knockout_reg;
    assign stage      = stage_reg;
    assign hit_count  = hit_count_reg;
    assign busy       = (state_reg == SETTLE) || (state_reg == ARMED);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_knockout_trigger_sequencer.sv
// Bench for knockout_trigger_sequencer: per-cycle stimulus vectors with
// expected post-edge outputs, passed through an expectation queue, plus a few
// hand-written sequences around asynchronous reset.
module tb_knockout_trigger_sequencer;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_inst0;
    logic [31:0] cfg_inst1;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_count;
    logic        cfg_last;
    logic        arm;
    logic        disarm;
    logic        inst_valid;
    logic        trig1;
    logic        trig2;
    logic [31:0] inst0_trig;
    logic [31:0] inst1_trig;
    logic        knockout;
    logic [1:0]  stage;
    logic [7:0]  hit_count;
    logic        busy;
    logic        done;

    knockout_trigger_sequencer #(
        .DEPTH   (4),
        .CNT_W   (8),
        .TRIG_LAT(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_inst0 (cfg_inst0),
        .cfg_inst1 (cfg_inst1),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .cfg_last  (cfg_last),
        .arm       (arm),
        .disarm    (disarm),
        .inst_valid(inst_valid),
        .trig1     (trig1),
        .trig2     (trig2),
        .inst0_trig(inst0_trig),
        .inst1_trig(inst1_trig),
        .knockout  (knockout),
        .stage     (stage),
        .hit_count (hit_count),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs required right after its edge.
    typedef struct {
        logic        iv, t1, t2, arm, dis, we;
        logic        ko;
        logic [7:0]  hc;
        logic [1:0]  stg;
        logic        busy, done;
        logic [31:0] i0;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vidx     = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", nm, idx, act, req);
        end
    endtask

    function automatic void add(input logic iv, input logic t1, input logic t2,
                                input logic a, input logic dis, input logic we,
                                input logic ko, input logic [7:0] hc,
                                input logic [1:0] stg, input logic bsy,
                                input logic dn, input logic [31:0] i0);
        vec_t v;
        v.iv = iv; v.t1 = t1; v.t2 = t2; v.arm = a; v.dis = dis; v.we = we;
        v.ko = ko; v.hc = hc; v.stg = stg; v.busy = bsy; v.done = dn; v.i0 = i0;
        vecs.push_back(v);
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        inst_valid = v.iv;
        trig1      = v.t1;
        trig2      = v.t2;
        arm        = v.arm;
        disarm     = v.dis;
        cfg_we     = v.we;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("knockout",   vidx, 32'(knockout),  32'(e.ko));
        chk("hit_count",  vidx, 32'(hit_count), 32'(e.hc));
        chk("stage",      vidx, 32'(stage),     32'(e.stg));
        chk("busy",       vidx, 32'(busy),      32'(e.busy));
        chk("done",       vidx, 32'(done),      32'(e.done));
        chk("inst0_trig", vidx, inst0_trig,     e.i0);
        $display("vec %0d: ko=%0b hc=%0d stage=%0d busy=%0b done=%0b inst0=%08h",
                 vidx, knockout, hit_count, stage, busy, done, inst0_trig);
        vidx++;
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) step(vecs[i]);
        vecs.delete();
        inst_valid = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
        arm = 1'b0; disarm = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [1:0] m, input logic [7:0] c, input logic l);
        cfg_addr = a; cfg_inst0 = i0; cfg_inst1 = i1;
        cfg_mode = m; cfg_count = c; cfg_last = l;
        cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        $display("cfg write stage %0d inst0=%08h mode=%0b count=%0d last=%0b", a, i0, m, c, l);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_knockout"},   vidx, 32'(knockout),  0);
        chk({tag, "_hit_count"},  vidx, 32'(hit_count), 0);
        chk({tag, "_stage"},      vidx, 32'(stage),     0);
        chk({tag, "_busy"},       vidx, 32'(busy),      0);
        chk({tag, "_done"},       vidx, 32'(done),      0);
        chk({tag, "_inst0_trig"}, vidx, inst0_trig,     0);
        chk({tag, "_inst1_trig"}, vidx, inst1_trig,     0);
        $display("%s: outputs ko=%0b hc=%0d stage=%0d busy=%0b done=%0b inst0=%08h inst1=%08h",
                 tag, knockout, hit_count, stage, busy, done, inst0_trig, inst1_trig);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_inst0 = '0; cfg_inst1 = '0;
        cfg_mode = '0; cfg_count = '0; cfg_last = 1'b0;
        arm = 1'b0; disarm = 1'b0; inst_valid = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("reset");

        // Reset mid-ARMED: get to ARMED with one hit counted, then pulse rst.
        cfg_wr(2'd0, 32'h00000013, 32'h00000033, 2'b01, 8'd3, 1'b1);
        add(1,0,0,1,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,0,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,0,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd1,2'd0,1,0,32'h00000013);
        run_vecs();
        chk("inst1_trig_armed", vidx, inst1_trig, 32'h00000033);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        // The table was cleared, so arming loads zero patterns.
        add(1,0,0,1,0,0, 0,8'd0,2'd0,1,0,32'h0);
        add(0,0,0,0,1,0, 0,8'd0,2'd0,0,0,32'h0);
        run_vecs();

        // Count and latency: three hits on trig1, trig ignored while settling.
        cfg_wr(2'd0, 32'h00000013, 32'h00000033, 2'b01, 8'd3, 1'b1);
        add(1,0,0,1,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd1,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd2,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 1,8'd0,2'd0,0,1,32'h00000013);
        add(1,1,0,1,0,0, 0,8'd0,2'd0,0,1,32'h00000013);
        add(0,0,0,0,1,0, 0,8'd0,2'd0,0,0,32'h00000013);
        run_vecs();

        // Multi-stage advance.
        cfg_wr(2'd0, 32'h11111111, 32'h0, 2'b10, 8'd1, 1'b0);
        cfg_wr(2'd1, 32'hDEADBEEF, 32'h0, 2'b11, 8'd2, 1'b1);
        add(1,0,0,1,0,0, 0,8'd0,2'd0,1,0,32'h11111111);
        add(1,0,1,0,0,0, 0,8'd0,2'd0,1,0,32'h11111111);
        add(1,0,1,0,0,0, 0,8'd0,2'd0,1,0,32'h11111111);
        add(1,1,0,0,0,0, 0,8'd0,2'd0,1,0,32'h11111111);
        add(1,0,1,0,0,0, 1,8'd0,2'd1,1,0,32'hDEADBEEF);
        add(1,1,1,0,0,0, 0,8'd0,2'd1,1,0,32'hDEADBEEF);
        add(1,1,0,0,0,0, 0,8'd0,2'd1,1,0,32'hDEADBEEF);
        add(1,1,1,0,0,0, 0,8'd1,2'd1,1,0,32'hDEADBEEF);
        add(1,0,1,0,0,0, 1,8'd0,2'd1,0,1,32'hDEADBEEF);
        add(0,0,0,0,1,0, 0,8'd0,2'd0,0,0,32'hDEADBEEF);
        run_vecs();

        // Qualification, ignored cfg write while ARMED, disarm on final hit.
        cfg_wr(2'd0, 32'h00000013, 32'h00000033, 2'b11, 8'd3, 1'b1);
        cfg_addr  = 2'd0;
        cfg_inst0 = 32'hBADBAD00;
        add(1,0,0,1,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(0,0,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,0,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(1,1,1,0,0,1, 0,8'd1,2'd0,1,0,32'h00000013);
        add(1,1,0,0,0,0, 0,8'd2,2'd0,1,0,32'h00000013);
        add(1,1,0,0,1,0, 0,8'd0,2'd0,0,0,32'h00000013);
        add(1,0,0,1,0,0, 0,8'd0,2'd0,1,0,32'h00000013);
        add(0,0,0,0,1,0, 0,8'd0,2'd0,0,0,32'h00000013);
        run_vecs();

        // Zero counts, no last flag: one knockout per hit, DONE at table end.
        for (int k = 0; k < 4; k++) begin
            cfg_wr(2'(k), 32'h00000100 + 32'(k), 32'h0, 2'b01, 8'd0, 1'b0);
        end
        cfg_addr  = 2'd0;
        cfg_inst0 = 32'h77777777;
        // arm with a same-cycle write sees the old stage-0 pattern
        add(1,0,0,1,0,1, 0,8'd0,2'd0,1,0,32'h00000100);
        for (int k = 0; k < 4; k++) begin
            add(1,0,0,0,0,0, 0,8'd0,2'(k),1,0,32'h00000100 + 32'(k));
            add(1,0,0,0,0,0, 0,8'd0,2'(k),1,0,32'h00000100 + 32'(k));
            if (k < 3) begin
                add(1,1,0,0,0,0, 1,8'd0,2'(k + 1),1,0,32'h00000100 + 32'(k + 1));
            end else begin
                add(1,1,0,0,0,0, 1,8'd0,2'd3,0,1,32'h00000103);
            end
        end
        add(1,1,0,1,0,0, 0,8'd0,2'd3,0,1,32'h00000103);
        add(0,0,0,0,1,0, 0,8'd0,2'd0,0,0,32'h00000103);
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
